ext_bus_wb_master: RTL and testbench

Bridges the 8-bit asynchronous SRAM-style host CPU interface (addr/data/nwe/noe/ncs) onto a 32-bit Wishbone master port. The port connects to a free conbus master slot (m2), so an external processor can read and write bram, uart, timer, gpio and spi space, for example to load firmware. Host strobes are synchronised into the system clock domain. Each host byte access becomes one single-beat Wishbone cycle.

---
 rtl/ext_bus_wb_master_if.sv | 24 ++
 rtl/ext_bus_wb_master.sv | 191 +++++++++++++++++++
 tb/tb_ext_bus_wb_master.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_wb_master_if.sv
// ext_bus_wb_master_if: Wishbone signal bundle for ext_bus_wb_master.
//   master modport : drives wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o/wb_cyc_o/wb_stb_o,
//                    receives wb_dat_i/wb_ack_i
//   slave modport  : the mirror image, for the conbus slot or a bench model
interface ext_bus_wb_master_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/ext_bus_wb_master.sv
// ext_bus_wb_master: bridges an 8-bit asynchronous SRAM-style host bus onto a
// 32-bit Wishbone master. Each host byte write/read becomes one single-beat
// Wishbone cycle with big-endian byte lanes.
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   bus_addr/bus_data_i  host byte address and write data (asynchronous)
//   bus_data_o/_oe       host read data and its drive enable for the pad tristate
//   bus_nwe/noe/ncs      host strobes, active-low (asynchronous)
//   wb                   Wishbone master signals (ext_bus_wb_master_if.master)
//   busy                 Wishbone cycle in progress
//   err                  sticky: timeout or overrun seen since reset
module ext_bus_wb_master #(
    parameter logic [31:0] base_addr = 32'h0000_0000,
    parameter int unsigned timeout   = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [12:0]                bus_addr,
    input  logic [7:0]                 bus_data_i,
    output logic [7:0]                 bus_data_o,
    output logic                       bus_data_oe,
    input  logic                       bus_nwe,
    input  logic                       bus_noe,
    input  logic                       bus_ncs,
    ext_bus_wb_master_if.master        wb,
    output logic                       busy,
    output logic                       err
);
    localparam int unsigned CW = $clog2(timeout + 1);

    typedef enum logic [1:0] {IDLE, WR, RD, HOLD} state_t;
    state_t state, state_next;

    // Synchronisers and matching two-stage pipeline for address/data
    logic [1:0]  ncs_sync, nwe_sync, noe_sync;
    logic        s_ncs, s_nwe, s_noe;
    logic        s_ncs_d, s_nwe_d, s_noe_d;
    logic [12:0] addr_p1, addr_p2;
    logic [7:0]  data_p1, data_p2;
    logic [2:0]  armed_sr;
    logic        armed;

    // Cycle state
    logic [CW-1:0] cnt;
    logic [31:0]   adr_q, dat_q;
    logic [3:0]    sel_q;
    logic [1:0]    lane_q;
    logic [7:0]    rd_byte;
    logic          wr_trig, rd_trig, to_hit, set_err;

    assign s_ncs = ncs_sync[1];
    assign s_nwe = nwe_sync[1];
    assign s_noe = noe_sync[1];

    // Edge detection only becomes valid once the delayed strobe copies hold
    // genuinely sampled pin values; until then a strobe already low at reset
    // release would look like a fresh edge against the reset value.
    assign armed = armed_sr[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ncs_sync <= '1;
            nwe_sync <= '1;
            noe_sync <= '1;
            s_ncs_d  <= 1'b1;
            s_nwe_d  <= 1'b1;
            s_noe_d  <= 1'b1;
            addr_p1  <= '0;
            addr_p2  <= '0;
            data_p1  <= '0;
            data_p2  <= '0;
            armed_sr <= '0;
        end else begin
            ncs_sync <= {ncs_sync[0], bus_ncs};
            nwe_sync <= {nwe_sync[0], bus_nwe};
            noe_sync <= {noe_sync[0], bus_noe};
            s_ncs_d  <= s_ncs;
            s_nwe_d  <= s_nwe;
            s_noe_d  <= s_noe;
            addr_p1  <= bus_addr;
            addr_p2  <= addr_p1;
            data_p1  <= bus_data_i;
            data_p2  <= data_p1;
            armed_sr <= {armed_sr[1:0], 1'b1};
        end
    end

    assign wr_trig = armed && s_nwe && !s_nwe_d && !s_ncs_d;
    assign rd_trig = armed && !s_noe && s_noe_d && !s_ncs;
    assign to_hit  = (cnt == CW'(timeout - 1));

    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = wb.wb_dat_i[31:24];
            2'd1:    rd_byte = wb.wb_dat_i[23:16];
            2'd2:    rd_byte = wb.wb_dat_i[15:8];
            default: rd_byte = wb.wb_dat_i[7:0];
        endcase
    end

    // Next state, overrun/timeout flagging and decoded outputs
    always_comb begin
        state_next  = state;
        set_err     = 1'b0;
        busy        = 1'b0;
        wb.wb_cyc_o = 1'b0;
        wb.wb_stb_o = 1'b0;
        wb.wb_we_o  = 1'b0;
        bus_data_oe = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_trig) begin
                    state_next = WR;
                    set_err    = rd_trig;
                end else if (rd_trig) begin
                    state_next = RD;
                end
            end
            WR: begin
                busy        = 1'b1;
                wb.wb_cyc_o = 1'b1;
                wb.wb_stb_o = 1'b1;
                wb.wb_we_o  = 1'b1;
                set_err     = wr_trig || rd_trig;
                if (wb.wb_ack_i) begin
                    state_next = IDLE;
                end else if (to_hit) begin
                    state_next = IDLE;
                    set_err    = 1'b1;
                end
            end
            RD: begin
                busy        = 1'b1;
                wb.wb_cyc_o = 1'b1;
                wb.wb_stb_o = 1'b1;
                set_err     = wr_trig || rd_trig;
                if (wb.wb_ack_i) begin
                    state_next = HOLD;
                end else if (to_hit) begin
                    state_next = HOLD;
                    set_err    = 1'b1;
                end
            end
            HOLD: begin
                bus_data_oe = !s_noe && !s_ncs;
                set_err     = wr_trig || rd_trig;
                if (s_noe || s_ncs) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            lane_q     <= '0;
            bus_data_o <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            err   <= err | set_err;
            if (state == IDLE && (wr_trig || rd_trig)) begin
                cnt    <= '0;
                adr_q  <= base_addr | {19'b0, addr_p2[12:2], 2'b00};
                sel_q  <= 4'b1000 >> addr_p2[1:0];
                lane_q <= addr_p2[1:0];
                if (wr_trig) begin
                    dat_q <= {4{data_p2}};
                end
            end else if (busy) begin
                cnt <= cnt + CW'(1);
            end
            if (state == RD) begin
                if (wb.wb_ack_i) begin
                    bus_data_o <= rd_byte;
                end else if (to_hit) begin
                    bus_data_o <= 8'hFF;
                end
            end
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
endmodule

// File: tb/tb_ext_bus_wb_master.sv
// tb_ext_bus_wb_master: directed self-checking bench for ext_bus_wb_master.
// Two instances share the host address/data/strobe wires but have separate
// chip selects: dut_a uses default parameters, dut_b uses a 0x2000_0000 base
// and an 8-clock timeout. Each has a small Wishbone slave model with
// programmable ack latency.
module tb_ext_bus_wb_master;
    logic        clk;
    logic        rst;
    logic [12:0] bus_addr;
    logic [7:0]  bus_data_i;
    logic        bus_nwe, bus_noe, ncs_a, ncs_b;
    logic [7:0]  data_o_a, data_o_b;
    logic        oe_a, oe_b, busy_a, busy_b, err_a, err_b;

    ext_bus_wb_master_if ifa ();
    ext_bus_wb_master_if ifb ();

    ext_bus_wb_master dut_a (
        .clk(clk), .reset(rst),
        .bus_addr(bus_addr), .bus_data_i(bus_data_i),
        .bus_data_o(data_o_a), .bus_data_oe(oe_a),
        .bus_nwe(bus_nwe), .bus_noe(bus_noe), .bus_ncs(ncs_a),
        .wb(ifa), .busy(busy_a), .err(err_a)
    );

    ext_bus_wb_master #(.base_addr(32'h2000_0000), .timeout(8)) dut_b (
        .clk(clk), .reset(rst),
        .bus_addr(bus_addr), .bus_data_i(bus_data_i),
        .bus_data_o(data_o_b), .bus_data_oe(oe_b),
        .bus_nwe(bus_nwe), .bus_noe(bus_noe), .bus_ncs(ncs_b),
        .wb(ifb), .busy(busy_b), .err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave models: ack after a_lat/b_lat clocks of cyc, capture each cycle start
    int          a_lat = 1, b_lat = 1;
    logic        a_noack = 1'b0, b_noack = 1'b0;
    logic [31:0] a_rdata = '0, b_rdata = '0;
    int          a_wait, b_wait;
    int          a_cycles = 0, b_cycles = 0;
    logic        a_cyc_d, b_cyc_d;
    logic [31:0] a_adr, a_dat, b_adr, b_dat;
    logic [3:0]  a_sel, b_sel;
    logic        a_we, b_we;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ifa.wb_ack_i <= 1'b0;
            ifa.wb_dat_i <= '0;
            a_wait       <= 0;
            a_cyc_d      <= 1'b0;
        end else begin
            a_cyc_d <= ifa.wb_cyc_o;
            if (ifa.wb_cyc_o && !a_cyc_d) begin
                a_cycles <= a_cycles + 1;
                a_adr    <= ifa.wb_adr_o;
                a_dat    <= ifa.wb_dat_o;
                a_sel    <= ifa.wb_sel_o;
                a_we     <= ifa.wb_we_o;
            end
            if (ifa.wb_cyc_o && ifa.wb_stb_o && !ifa.wb_ack_i && !a_noack) begin
                if (a_wait >= a_lat - 1) begin
                    ifa.wb_ack_i <= 1'b1;
                    ifa.wb_dat_i <= a_rdata;
                    a_wait       <= 0;
                end else begin
                    a_wait <= a_wait + 1;
                end
            end else begin
                ifa.wb_ack_i <= 1'b0;
                a_wait       <= 0;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ifb.wb_ack_i <= 1'b0;
            ifb.wb_dat_i <= '0;
            b_wait       <= 0;
            b_cyc_d      <= 1'b0;
        end else begin
            b_cyc_d <= ifb.wb_cyc_o;
            if (ifb.wb_cyc_o && !b_cyc_d) begin
                b_cycles <= b_cycles + 1;
                b_adr    <= ifb.wb_adr_o;
                b_dat    <= ifb.wb_dat_o;
                b_sel    <= ifb.wb_sel_o;
                b_we     <= ifb.wb_we_o;
            end
            if (ifb.wb_cyc_o && ifb.wb_stb_o && !ifb.wb_ack_i && !b_noack) begin
                if (b_wait >= b_lat - 1) begin
                    ifb.wb_ack_i <= 1'b1;
                    ifb.wb_dat_i <= b_rdata;
                    b_wait       <= 0;
                end else begin
                    b_wait <= b_wait + 1;
                end
            end else begin
                ifb.wb_ack_i <= 1'b0;
                b_wait       <= 0;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic host_write(input bit to_b, input logic [12:0] a, input logic [7:0] d);
        bus_addr   = a;
        bus_data_i = d;
        if (to_b) ncs_b = 1'b0;
        else      ncs_a = 1'b0;
        repeat (4) @(negedge clk);
        bus_nwe = 1'b0;
        repeat (4) @(negedge clk);
        bus_nwe = 1'b1;
        repeat (4) @(negedge clk);
        ncs_a = 1'b1;
        ncs_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int len;
        int snap;
        rst        = 1'b1;
        bus_addr   = '0;
        bus_data_i = '0;
        bus_nwe    = 1'b1;
        bus_noe    = 1'b1;
        ncs_a      = 1'b1;
        ncs_b      = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cyc",  ifa.wb_cyc_o, 0);
        chk("rst_stb",  ifa.wb_stb_o, 0);
        chk("rst_we",   ifa.wb_we_o, 0);
        chk("rst_adr",  ifa.wb_adr_o, 0);
        chk("rst_sel",  ifa.wb_sel_o, 0);
        chk("rst_dato", ifa.wb_dat_o, 0);
        chk("rst_data", data_o_a, 0);
        chk("rst_oe",   oe_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_err",  err_a, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write 0x0005 <- A5, 1-clk slave
        host_write(0, 13'h0005, 8'hA5);
        repeat (4) @(negedge clk);
        chk("wr_cycles", a_cycles, 1);
        chk("wr_adr",    a_adr, 32'h0000_0004);
        chk("wr_sel",    a_sel, 4'b0100);
        chk("wr_dat",    a_dat, 32'hA5A5_A5A5);
        chk("wr_we",     a_we, 1);
        chk("wr_err",    err_a, 0);
        chk("wr_busy",   busy_a, 0);

        // Read 0x0013, slave returns 11223344
        a_rdata  = 32'h1122_3344;
        bus_addr = 13'h0013;
        ncs_a    = 1'b0;
        repeat (4) @(negedge clk);
        bus_noe = 1'b0;
        repeat (8) @(negedge clk);
        chk("rd_oe",     oe_a, 1);
        chk("rd_data",   data_o_a, 8'h44);
        chk("rd_adr",    a_adr, 32'h0000_0010);
        chk("rd_sel",    a_sel, 4'b0001);
        chk("rd_we",     a_we, 0);
        chk("rd_cycles", a_cycles, 2);
        bus_noe = 1'b1;
        repeat (4) @(negedge clk);
        chk("rd_oe_off", oe_a, 0);
        chk("rd_busy",   busy_a, 0);
        ncs_a = 1'b1;
        repeat (4) @(negedge clk);

        // Read on dut_b with no ack: 8-clk timeout
        b_noack  = 1'b1;
        bus_addr = 13'h0000;
        ncs_b    = 1'b0;
        repeat (4) @(negedge clk);
        bus_noe = 1'b0;
        k = 0;
        while (!ifb.wb_cyc_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("to_cyc_seen", ifb.wb_cyc_o, 1);
        len = 0;
        while (ifb.wb_cyc_o && len < 40) begin
            @(negedge clk);
            len++;
        end
        chk("to_len", len, 8);
        repeat (2) @(negedge clk);
        chk("to_data", data_o_b, 8'hFF);
        chk("to_err",  err_b, 1);
        chk("to_oe",   oe_b, 1);
        bus_noe = 1'b1;
        repeat (4) @(negedge clk);
        chk("to_oe_off", oe_b, 0);
        ncs_b = 1'b1;
        repeat (4) @(negedge clk);

        // Base address on dut_b: write 0x1FFF <- 3C
        b_noack = 1'b0;
        host_write(1, 13'h1FFF, 8'h3C);
        repeat (4) @(negedge clk);
        chk("base_cycles", b_cycles, 2);
        chk("base_adr",    b_adr, 32'h2000_1FFC);
        chk("base_sel",    b_sel, 4'b0001);
        chk("base_dat",    b_dat, 32'h3C3C_3C3C);

        // Overrun: second nwe pulse while a 20-clk slave stalls the first write
        a_lat      = 20;
        bus_addr   = 13'h0008;
        bus_data_i = 8'h11;
        ncs_a      = 1'b0;
        repeat (4) @(negedge clk);
        bus_nwe = 1'b0;
        repeat (3) @(negedge clk);
        bus_nwe = 1'b1;
        repeat (3) @(negedge clk);
        bus_nwe = 1'b0;
        repeat (3) @(negedge clk);
        bus_nwe = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovr_busy_mid", busy_a, 1);
        chk("ovr_err_mid",  err_a, 1);
        repeat (30) @(negedge clk);
        chk("ovr_cycles", a_cycles, 3);
        chk("ovr_busy",   busy_a, 0);
        chk("ovr_err",    err_a, 1);
        chk("ovr_dat",    a_dat, 32'h1111_1111);

        // Reset in the middle of a stalled write
        bus_addr = 13'h0020;
        bus_nwe  = 1'b0;
        repeat (3) @(negedge clk);
        bus_nwe = 1'b1;
        k = 0;
        while (!ifa.wb_cyc_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_cyc_seen", ifa.wb_cyc_o, 1);
        bus_nwe = 1'b0;
        bus_noe = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_cyc",  ifa.wb_cyc_o, 0);
        chk("arst_stb",  ifa.wb_stb_o, 0);
        chk("arst_we",   ifa.wb_we_o, 0);
        chk("arst_busy", busy_a, 0);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        snap = a_cycles;
        repeat (12) @(negedge clk);
        chk("post_cycles", a_cycles, snap);
        chk("post_busy",   busy_a, 0);
        chk("post_err",    err_a, 0);
        chk("post_oe",     oe_a, 0);
        ncs_a = 1'b1;
        repeat (4) @(negedge clk);
        bus_nwe = 1'b1;
        bus_noe = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
